// File: rtl/instruction_fetch_stage_pkg.sv
// Shared front-end definitions used by fetch and decode: NOP encoding, major
// opcodes and the fetch FSM state type.
package instruction_fetch_stage_pkg;

  localparam logic [31:0] RV_NOP    = 32'h0000_0013;

  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef enum logic {
    S_REQ,
    S_WAIT
  } fetch_state_e;

  // Instruction addresses are word aligned; low bits from branch targets are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_parity_checker.sv
// Even-parity check on a 32-bit word plus its parity bit; reusable on the
// data-memory path. ENABLE = 0 ties the error output low.
module parity_checker #(
  parameter bit ENABLE = 1'b1
) (
  input  logic [31:0] i_data,
  input  logic        i_parity,
  output logic        o_err
);

  assign o_err = ENABLE & (^{i_data, i_parity});

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: one outstanding imem request, parity-checked responses, and a
// valid/ready output register toward decode with branch redirect/flush.
//
// state  | meaning
// S_REQ  | presenting imem request at pc
// S_WAIT | request accepted, waiting to accept its response
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          PARITY_EN = 1'b1,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_addr,
  input  logic             imem_resp_valid,
  output logic             imem_resp_ready,
  input  logic [31:0]      imem_resp_data,
  input  logic             imem_resp_parity,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             parity_err,
  output logic [CNT_W-1:0] parity_err_cnt
);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_inflight_pc;
  logic             r_squash;
  logic             r_id_valid;
  logic [31:0]      r_id_instr;
  logic [31:0]      r_id_pc;
  logic             r_parity_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_req_fire;
  logic w_resp_fire;
  logic w_load;
  logic w_par_err;
  logic w_perr_evt;
  logic w_squash_nxt;

  assign imem_req_valid  = !rst && (r_state == S_REQ);
  assign imem_addr       = r_pc;
  // A squashed response is always drained, even while decode is stalled.
  assign imem_resp_ready = !rst && (r_state == S_WAIT) &&
                           (r_squash || !r_id_valid || id_ready);

  assign w_req_fire  = imem_req_valid && imem_req_ready;
  assign w_resp_fire = imem_resp_valid && imem_resp_ready;
  assign w_load      = w_resp_fire && !r_squash && !redirect_valid;
  assign w_perr_evt  = w_load && w_par_err;

  parity_checker #(
    .ENABLE (PARITY_EN)
  ) u_parity (
    .i_data   (imem_resp_data),
    .i_parity (imem_resp_parity),
    .o_err    (w_par_err)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_squash_nxt = r_squash;
    case (r_state)
      S_REQ:  if (w_req_fire)  w_state_nxt = S_WAIT;
      S_WAIT: if (w_resp_fire) w_state_nxt = S_REQ;
    endcase
    // Squash marks a request whose response belongs to the pre-redirect path.
    if (redirect_valid) begin
      w_squash_nxt = w_req_fire || ((r_state == S_WAIT) && !w_resp_fire);
    end else if (w_resp_fire) begin
      w_squash_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_squash      <= 1'b0;
      r_id_valid    <= 1'b0;
      r_id_instr    <= RV_NOP;
      r_id_pc       <= 32'h0000_0000;
      r_parity_err  <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_squash <= w_squash_nxt;
      if (w_req_fire) r_inflight_pc <= r_pc;

      if (redirect_valid) begin
        r_pc <= align_pc(redirect_pc);
      end else if (w_load) begin
        r_pc <= r_pc + 32'd4;
      end

      if (redirect_valid) begin
        r_id_valid <= 1'b0;
      end else if (w_load) begin
        r_id_valid <= 1'b1;
        r_id_instr <= w_par_err ? RV_NOP : imem_resp_data;
        r_id_pc    <= r_inflight_pc;
      end else if (id_ready) begin
        r_id_valid <= 1'b0;
      end

      r_parity_err <= w_perr_evt;
      if (w_perr_evt && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign id_valid       = r_id_valid;
  assign id_instr       = r_id_instr;
  assign id_pc          = r_id_pc;
  assign parity_err     = r_parity_err;
  assign parity_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a 1-cycle-latency memory model
// with a request budget, directed scenarios pushing expected {instr, pc}.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_resp_parity = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        parity_err;
  logic [7:0]  parity_err_cnt;

  always #5 clk = ~clk;

  instruction_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .PARITY_EN (1'b1),
    .CNT_W     (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_ready  (imem_resp_ready),
    .imem_resp_data   (imem_resp_data),
    .imem_resp_parity (imem_resp_parity),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .parity_err       (parity_err),
    .parity_err_cnt   (parity_err_cnt)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] req_log[$];
  int          hs_cyc[$];
  int          cyc = 0;
  int          req_budget = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] corrupt_addr = 32'h1;
  logic        corrupt_all = 1'b0;
  logic [63:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0020_81B3;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic push_exp(input int n, input logic bad);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({bad ? NOP : mem_word(exp_pc), exp_pc});
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // One clock: sample handshakes before the edge, update the memory model after it.
  task automatic tick();
    logic        pre_req;
    logic        pre_resp;
    logic [31:0] a;
    @(negedge clk);
    imem_req_ready = (req_budget > 0);
    #1;
    pre_req  = imem_req_valid && imem_req_ready;
    pre_resp = imem_resp_valid && imem_resp_ready;
    a        = imem_addr;
    if (pre_req) req_log.push_back(a);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      imem_resp_valid = 1'b0;
    end else begin
      if (pre_resp) imem_resp_valid = 1'b0;
      if (pre_req) begin
        req_budget--;
        imem_resp_valid  = 1'b1;
        imem_resp_data   = mem_word(a);
        imem_resp_parity = (^mem_word(a)) ^ (corrupt_all || (a == corrupt_addr));
      end
    end
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || req_budget != 0) && n < max) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && id_valid && id_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected actual pc=%h instr=%h required none", id_pc, id_instr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_instr", id_instr, mon_e[63:32]);
        chk("sb_pc", id_pc, mon_e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state and basic in-order fetch
    repeat (3) tick();
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_resp_ready", 32'(imem_resp_ready), 0);
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_cnt", 32'(parity_err_cnt), 0);
    rst = 1'b0;
    id_ready = 1'b1;
    req_log.delete();
    hs_cyc.delete();
    exp_pc = 32'h0;
    req_budget = 3;
    push_exp(3, 1'b0);
    drain(40);
    chk("t1_nreq", req_log.size(), 3);
    chk("t1_addr0", req_log[0], 32'h0);
    chk("t1_addr1", req_log[1], 32'h4);
    chk("t1_addr2", req_log[2], 32'h8);
    chk("t1_nhs", hs_cyc.size(), 3);
    chk("t1_rate", hs_cyc[2] - hs_cyc[0], 4);

    // decode stall holds the output register and blocks the next response
    req_budget = 1;
    push_exp(1, 1'b0);
    drain(20);
    id_ready = 1'b0;
    req_budget = 2;
    push_exp(2, 1'b0);
    n = 0;
    while (!(id_valid && id_pc == 32'h10) && n < 10) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(id_valid), 1);
      chk("t2_hold_instr", id_instr, 32'h0020_81B3);
      chk("t2_hold_pc", id_pc, 32'h10);
      tick();
    end
    chk("t2_resp_pending", 32'(imem_resp_valid), 1);
    chk("t2_resp_ready", 32'(imem_resp_ready), 0);
    chk("t2_pc_held", imem_addr, 32'h14);
    id_ready = 1'b1;
    drain(20);

    // parity error on the word at 0x8, then counter saturation
    redirect_to(32'h8);
    chk("t3_redir_idle_addr", imem_addr, 32'h8);
    chk("t3_redir_idle_req", 32'(imem_req_valid), 1);
    exp_pc = 32'h8;
    corrupt_addr = 32'h8;
    req_budget = 1;
    push_exp(1, 1'b1);
    n = 0;
    while (!parity_err && n < 10) begin tick(); n++; end
    chk("t3_perr_hi", 32'(parity_err), 1);
    chk("t3_cnt1", 32'(parity_err_cnt), 1);
    chk("t3_nop", id_instr, NOP);
    chk("t3_pc", id_pc, 32'h8);
    tick();
    chk("t3_perr_lo", 32'(parity_err), 0);
    drain(20);
    chk("t3_cnt_still1", 32'(parity_err_cnt), 1);
    corrupt_addr = 32'h1;
    corrupt_all = 1'b1;
    req_budget = 300;
    push_exp(300, 1'b1);
    drain(1000);
    chk("t3_cnt_sat", 32'(parity_err_cnt), 255);
    corrupt_all = 1'b0;

    // redirect while waiting for 0x4 with a stalled entry held
    redirect_to(32'h0);
    id_ready = 1'b0;
    req_budget = 2;
    n = 0;
    while (!(imem_resp_valid && id_valid) && n < 20) begin tick(); n++; end
    chk("t4_held_pc", id_pc, 32'h0);
    chk("t4_resp_blocked", 32'(imem_resp_ready), 0);
    redirect_to(32'h103);
    chk("t4_flush_valid", 32'(id_valid), 0);
    chk("t4_new_pc", imem_addr, 32'h100);
    exp_pc = 32'h100;
    req_budget = 1;
    push_exp(1, 1'b0);
    id_ready = 1'b1;
    drain(20);
    chk("t4_last_req", req_log[$], 32'h100);
    chk("t4_prev_req", req_log[$-1], 32'h4);
    chk("t4_cnt_kept", 32'(parity_err_cnt), 255);

    // redirect coincident with request acceptance at 0x20
    redirect_to(32'h20);
    req_log.delete();
    req_budget = 1;
    redirect_to(32'h80);
    chk("t5_nreq_a", req_log.size(), 1);
    chk("t5_old_req", req_log[0], 32'h20);
    chk("t5_in_wait", 32'(imem_req_valid), 0);
    exp_pc = 32'h80;
    req_budget = 1;
    push_exp(1, 1'b0);
    drain(20);
    chk("t5_nreq_b", req_log.size(), 2);
    chk("t5_new_req", req_log[1], 32'h80);

    // pc wrap and reset while a response is outstanding
    req_log.delete();
    redirect_to(32'hFFFF_FFFF);
    exp_pc = 32'hFFFF_FFFC;
    req_budget = 2;
    push_exp(2, 1'b0);
    drain(20);
    chk("t6_nreq", req_log.size(), 2);
    chk("t6_top", req_log[0], 32'hFFFF_FFFC);
    chk("t6_wrap", req_log[1], 32'h0);
    req_budget = 1;
    n = 0;
    while (!imem_resp_valid && n < 10) begin tick(); n++; end
    rst = 1'b1;
    tick();
    tick();
    chk("t6_rst_req_valid", 32'(imem_req_valid), 0);
    chk("t6_rst_resp_ready", 32'(imem_resp_ready), 0);
    chk("t6_rst_id_valid", 32'(id_valid), 0);
    chk("t6_rst_cnt", 32'(parity_err_cnt), 0);
    rst = 1'b0;
    req_log.delete();
    exp_pc = 32'h0;
    req_budget = 1;
    push_exp(1, 1'b0);
    drain(20);
    chk("t6_first_addr", req_log[0], 32'h0);

    repeat (2) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
